// File: rtl/adder_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial adder sequencer.
package adder_ctrl_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice: a + b + cin -> sum, cout. Zero latency, no flow control.
module nibble_add
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds WIDTH-bit operands one nibble per cycle through one shared 4-bit slice; result valid WIDTH/4 edges after accept,
// held while ready_i is low, new op accepted only in IDLE. ADDER_SUB_MODE_EN adds sub_i for A-B.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
`ifdef ADDER_SUB_MODE_EN
  input  logic             sub_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             busy_o
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e               state;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic [NIBBLE_W-1:0]  nib_sum;
  logic                 nib_cout;
  logic                 sub;

`ifdef ADDER_SUB_MODE_EN
  assign sub = sub_i;
`else
  assign sub = 1'b0;
`endif

  // Operands shift right so the slice always sees the current nibble at bit 0.
  nibble_add u_nibble_add (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      sum_o   <= '0;
      carry_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            a_sh    <= a_i;
            b_sh    <= sub ? ~b_i : b_i;
            carry   <= sub ? 1'b1 : carry_i;
            idx     <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          carry <= nib_cout;
          sum_o[int'(idx) * NIBBLE_W +: NIBBLE_W] <= nib_sum;
          if (idx == LAST_IDX) begin
            idx     <= '0;
            carry_o <= nib_cout;
            valid_o <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: driver pushes reference results, a negedge monitor pops and checks them.
module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_i = 1'b1;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             carry_i = 1'b0;
`ifdef ADDER_SUB_MODE_EN
  logic             sub = 1'b0;
`endif
  logic             ready_o, valid_o, carry_o, busy_o;
  logic [WIDTH-1:0] sum_o;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .carry_i (carry_i),
`ifdef ADDER_SUB_MODE_EN
    .sub_i   (sub),
`endif
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             c;
    int               acc;
  } exp_t;
  exp_t q[$];

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  // Downstream ready: forced value for directed tests, random otherwise.
  bit rforce = 1'b1;
  bit rval   = 1'b1;
  always @(posedge clk) begin
    #1 ready_i = rforce ? rval : ($urandom_range(0, 3) != 0);
  end

  logic             pv = 1'b0, pr = 1'b0, pc = 1'b0;
  logic [WIDTH-1:0] ps = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_ready", busy_o, !ready_o);
      if (pv && !pr) begin
        chk("hold_valid", valid_o, 1'b1);
        chk("hold_sum", sum_o, ps);
        chk("hold_carry", carry_o, pc);
      end
      if (valid_o && !pv) begin
        if (q.size() == 0) chk("unexpected_result", 1'b1, 1'b0);
        else chk("latency", cyc - q[0].acc, NIBBLES);
      end
      if (valid_o && ready_i && q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sum", sum_o, e.sum);
        chk("carry", carry_o, e.c);
      end
      pv = valid_o; pr = ready_i; ps = sum_o; pc = carry_o;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic s);
    int n;
    logic [WIDTH:0] r;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      chk("accept_timeout", 1'b0, 1'b1);
      return;
    end
    a_i = a; b_i = b; carry_i = cin; valid_i = 1'b1;
`ifdef ADDER_SUB_MODE_EN
    sub = s;
`endif
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); carry_i = 1'($urandom);
    r = model(a, b, cin, s);
    e.sum = r[WIDTH-1:0]; e.c = r[WIDTH]; e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !ready_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset values
    #12;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_sum", sum_o, 0);
    chk("rst_carry", carry_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();

    // valid_i pulses while calculating must be ignored
    issue(16'h00FF, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("ready_in_calc", ready_o, 1'b0);
      valid_i = 1'b1; a_i = WIDTH'($urandom);
      @(negedge clk);
    end
    valid_i = 1'b0;
    drain();

    // Backpressure in DONE
    rval = 1'b0;
    issue(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", valid_o, 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_still_valid", valid_o, 1'b1);
    rval = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after", ready_o, 1'b1);
    chk("bp_valid_after", valid_o, 1'b0);
    drain();

    // Reset mid-calculation at idx=2
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready_o, 1'b1);
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_sum", sum_o, 0);
    chk("mid_rst_carry", carry_o, 1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0003, 16'h0004, 1'b0, 1'b0);
    drain();

`ifdef ADDER_SUB_MODE_EN
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    drain();
    issue(16'h0009, 16'h0002, 1'b0, 1'b1);
    drain();
`endif

    // Randomized traffic with random downstream backpressure
    rforce = 1'b0;
    for (int i = 0; i < 40; i++) begin
`ifdef ADDER_SUB_MODE_EN
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
`else
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
`endif
    end
    drain();
    rforce = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
